ipv4_src_extractor: RTL
=======================

IPV4_SRC_EXTRACTOR -- requirements
Module: ipv4_src_extractor

Interface
REQ-001 The block SHALL have parameter IP_ADDR_W, default 32, the width of the extracted IPv4 address.
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-004 The block SHALL have port data_i, input, 8, the frame byte, with byte 0 being the first destination-MAC byte (no preamble or SFD).
REQ-005 The block SHALL have port valid_i, input, 1, which qualifies data_i, sof_i, eof_i and err_i.
REQ-006 The block SHALL have port sof_i, input, 1, which marks the first byte of a frame.
REQ-007 The block SHALL have port eof_i, input, 1, which marks the last byte of a frame.
REQ-008 The block SHALL have port err_i, input, 1, a frame error (bad FCS or PHY error), sampled only on the eof beat.
REQ-009 The block SHALL have port learn_i, input, 1, sampled on the sof beat: 1 selects insert and 0 selects look-up for that frame.
REQ-010 The block SHALL have port insert_val_o, output, 1, a one-cycle insert request to the hash controller.
REQ-011 The block SHALL have port look_up_val_o, output, 1, a one-cycle look-up request to the hash controller.
REQ-012 The block SHALL have port ip_addr_o, output, IP_ADDR_W, the extracted source IPv4 address.
REQ-013 The block SHALL have port drop_cnt_o, output, 16, a saturating count of rejected frames.

Function
REQ-014 Beats with valid_i=0 SHALL be ignored; the state and the byte counter SHALL hold.
REQ-015 The FSM states SHALL be IDLE, HDR, WAIT_EOF and DROP.
REQ-016 In IDLE, a beat with sof_i=1 SHALL enter HDR with the byte counter at 1 and learn_i latched; non-sof beats SHALL be ignored.
REQ-017 In HDR, the 6-bit byte counter SHALL increment on each valid beat.
REQ-018 In HDR, byte 12 not equal to 0x08, byte 13 not equal to 0x00, or the upper nibble of byte 14 not equal to 4 SHALL transition to DROP.
REQ-019 In HDR, bytes 26..29 SHALL be shifted into a capture register MSB-first; after byte 29 the FSM SHALL transition to WAIT_EOF.
REQ-020 On the eof beat in WAIT_EOF with err_i=0, the cycle after that beat SHALL assert exactly one of insert_val_o (learn latched 1) or look_up_val_o (learn latched 0) for one cycle, and ip_addr_o SHALL update to the captured address; the FSM SHALL then return to IDLE.
REQ-021 ip_addr_o SHALL hold its value between requests.
REQ-022 insert_val_o and look_up_val_o SHALL never be asserted in the same cycle.
REQ-023 A frame with eof in HDR (shorter than 30 bytes), eof with err_i=1, or a frame that ends in DROP SHALL produce no request and SHALL increment drop_cnt_o by 1, once per frame.
REQ-024 drop_cnt_o SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-025 If sof_i=1 arrives in HDR, WAIT_EOF or DROP, the current frame SHALL count as a drop and the new frame SHALL start as in REQ-016 on the same beat.
REQ-026 If sof_i=1 and eof_i=1 occur on the same beat, the frame SHALL be a single-byte frame and SHALL count as a drop.
REQ-027 In DROP, the FSM SHALL wait for eof (or an abort by sof) before leaving the state.
REQ-028 The latency from the eof beat to the request SHALL be exactly 1 cycle.
REQ-029 Back-to-back frames with no idle beats SHALL be supported.

Reset
REQ-030 When rst=0 at a clk edge, the FSM SHALL go to IDLE and the byte counter, capture register, ip_addr_o and drop_cnt_o SHALL clear to 0.
REQ-031 When rst=0 at a clk edge, insert_val_o and look_up_val_o SHALL clear to 0.
REQ-032 A reset in mid-frame SHALL discard that frame with no request and no drop count; bytes SHALL be ignored until the next sof after rst=1.

Structure
REQ-033 ETHERTYPE_IPV4 (16'h0800), the byte offsets 12, 14, 26 and 29, and the FSM state enum SHALL be placed in the shared eth_parser_pkg.
REQ-034 The saturating counter SHALL be a sub-module, sat_counter, with parameter WIDTH.
REQ-035 No other sub-modules SHALL be used.

Verification
REQ-036 An IPv4 frame of 64 bytes with src 192.168.1.10 and learn_i=0 SHALL produce look_up_val_o=1 for one cycle, one cycle after eof, with ip_addr_o=32'hC0A8010A.
REQ-037 The same frame with learn_i=1 SHALL produce insert_val_o=1 only, with ip_addr_o=32'hC0A8010A.
REQ-038 An ARP frame (EtherType 0x0806) followed by an IPv4 frame with a 20-byte header and err_i=1 SHALL produce no requests and drop_cnt_o=2.
REQ-039 A 20-byte runt frame, a sof injected at byte 27, and then a complete frame with src 10.0.0.1 SHALL give drop_cnt_o=2 and one request with ip_addr_o=32'h0A000001.
REQ-040 A frame of 64 bytes with valid_i toggling every other cycle SHALL produce the same result as REQ-036.
REQ-041 A reset pulse at byte 28 followed by a good frame SHALL produce one request, drop_cnt_o=0, and no request for the aborted frame.

Source files
------------

// File: rtl/eth_parser_pkg.sv
// Shared definitions for the Ethernet/IPv4 header parsers.
//   - EtherType value that identifies an IPv4 payload
//   - byte offsets (from the first destination-MAC byte) of the header fields
//   - FSM state encoding used by the extractor
package eth_parser_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IPV4_VERSION   = 4'h4;

  // Offsets are sized to the extractor's 6-bit byte counter.
  localparam logic [5:0] OFF_ETYPE_HI  = 6'd12;
  localparam logic [5:0] OFF_ETYPE_LO  = 6'd13;
  localparam logic [5:0] OFF_VER_IHL   = 6'd14;
  localparam logic [5:0] OFF_SRC_FIRST = 6'd26;
  localparam logic [5:0] OFF_SRC_LAST  = 6'd29;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR      = 2'd1,
    WAIT_EOF = 2'd2,
    DROP     = 2'd3
  } eth_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset, clears the count
//   inc_i    - amount to add this cycle (0..3)
//   count_o  - current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   sum;

  // One extra bit catches the carry out so overflow can clamp.
  assign sum = {1'b0, count_q} + {{(WIDTH-1){1'b0}}, inc_i};

  always_comb begin
    count_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ipv4_src_extractor.sv
// Extracts the IPv4 source address from an Ethernet frame byte stream and
// issues one insert or look-up request to the hash controller per good frame.
// Ports:
//   clk            - clock
//   rst            - synchronous active-low reset
//   data_i         - frame byte (byte 0 = first destination-MAC byte)
//   valid_i        - qualifies data_i/sof_i/eof_i/err_i
//   sof_i, eof_i   - first / last byte of a frame
//   err_i          - frame error, looked at only on the eof beat
//   learn_i        - on the sof beat: 1 = insert, 0 = look-up
//   insert_val_o   - one-cycle insert request
//   look_up_val_o  - one-cycle look-up request
//   ip_addr_o      - source address of the last requested frame
//   drop_cnt_o     - saturating count of rejected frames
module ipv4_src_extractor
  import eth_parser_pkg::*;
#(
  parameter int IP_ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  input  logic                 sof_i,
  input  logic                 eof_i,
  input  logic                 err_i,
  input  logic                 learn_i,
  output logic                 insert_val_o,
  output logic                 look_up_val_o,
  output logic [IP_ADDR_W-1:0] ip_addr_o,
  output logic [15:0]          drop_cnt_o
);

  eth_state_e           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 learn_q, learn_d;
  logic [IP_ADDR_W-1:0] cap_q, cap_d;
  logic [IP_ADDR_W-1:0] ip_addr_q, ip_addr_d;
  logic                 ins_q, ins_d;
  logic                 lku_q, lku_d;
  logic [1:0]           drop_inc;
  logic [IP_ADDR_W-1:0] cap_shift;
  logic                 hdr_bad;

  assign cap_shift = {cap_q[IP_ADDR_W-9:0], data_i};

  // Header byte at the current counter position fails the IPv4 checks.
  always_comb begin
    hdr_bad = 1'b0;
    if (cnt_q == OFF_ETYPE_HI && data_i != ETHERTYPE_IPV4[15:8]) hdr_bad = 1'b1;
    if (cnt_q == OFF_ETYPE_LO && data_i != ETHERTYPE_IPV4[7:0])  hdr_bad = 1'b1;
    if (cnt_q == OFF_VER_IHL  && data_i[7:4] != IPV4_VERSION)    hdr_bad = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    learn_d   = learn_q;
    cap_d     = cap_q;
    ip_addr_d = ip_addr_q;
    ins_d     = 1'b0;
    lku_d     = 1'b0;
    drop_inc  = 2'd0;

    if (valid_i) begin
      if (sof_i) begin
        // A sof outside IDLE aborts the frame in flight. A sof+eof beat is a
        // one-byte frame of its own, so that beat can account for two drops.
        if (state_q != IDLE) drop_inc = 2'd1;
        if (eof_i) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          state_d = HDR;
          cnt_d   = 6'd1;
          learn_d = learn_i;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          HDR: begin
            cnt_d = cnt_q + 6'd1;
            // In HDR the counter never passes OFF_SRC_LAST.
            if (cnt_q >= OFF_SRC_FIRST) cap_d = cap_shift;
            if (eof_i) begin
              // Ending exactly on the last address byte is a complete frame.
              if (cnt_q == OFF_SRC_LAST && !err_i) begin
                ins_d     = learn_q;
                lku_d     = ~learn_q;
                ip_addr_d = cap_shift;
              end else begin
                drop_inc = 2'd1;
              end
              state_d = IDLE;
            end else if (hdr_bad) begin
              state_d = DROP;
            end else if (cnt_q == OFF_SRC_LAST) begin
              state_d = WAIT_EOF;
            end
          end
          WAIT_EOF: begin
            if (eof_i) begin
              if (!err_i) begin
                ins_d     = learn_q;
                lku_d     = ~learn_q;
                ip_addr_d = cap_q;
              end else begin
                drop_inc = 2'd1;
              end
              state_d = IDLE;
            end
          end
          DROP: begin
            if (eof_i) begin
              drop_inc = 2'd1;
              state_d  = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      learn_q   <= 1'b0;
      cap_q     <= '0;
      ip_addr_q <= '0;
      ins_q     <= 1'b0;
      lku_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      learn_q   <= learn_d;
      cap_q     <= cap_d;
      ip_addr_q <= ip_addr_d;
      ins_q     <= ins_d;
      lku_q     <= lku_d;
    end
  end

  sat_counter #(
    .WIDTH (16)
  ) u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (drop_inc),
    .count_o (drop_cnt_o)
  );

  assign insert_val_o  = ins_q;
  assign look_up_val_o = lku_q;
  assign ip_addr_o     = ip_addr_q;

endmodule
